// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: issue/writeback sequencer between execute and the MULDIV unit.
// Holds one M-extension operation at a time, starts the unit, waits for done
// (guarded by a watchdog) and returns the result over a valid/ready port.
// Optional feature: define MULDIV_RESULT_CACHE_EN for a single-entry last-result cache.
module muldiv_issue_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        md_start,
    output logic [2:0]  md_op,
    output logic [31:0] md_A,
    output logic [31:0] md_B,
    input  logic        md_done,
    input  logic [31:0] md_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_DRAIN} state_t;

    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  wdog_q, wdog_d;
    logic        terr_q, terr_d;

    logic        accept;
    logic        cache_hit;
    logic [31:0] cache_data;
    logic [7:0]  wdog_inc;
    logic        wdog_expire;

    assign accept   = req_valid & req_ready;
    assign wdog_inc = wdog_q + 8'd1;
    // The counter value after this cycle's increment is compared, so the
    // watchdog fires in the cycle that completes TIMEOUT-1 counted cycles.
    assign wdog_expire = (wdog_inc == WDOG_LAST);

`ifdef MULDIV_RESULT_CACHE_EN
    logic        cv_q;
    logic [2:0]  cop_q;
    logic [31:0] ca_q, cb_q, cd_q;
    logic        capture;

    // Only genuine results taken from md_done (not flushed) refresh the cache.
    assign capture    = md_done & ~flush & ((state_q == S_ISSUE) | (state_q == S_WAIT));
    assign cache_hit  = cv_q & (cop_q == req_op) & (ca_q == req_rs1) & (cb_q == req_rs2);
    assign cache_data = cd_q;

    // Single-entry cache of the most recent completed operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cv_q  <= 1'b0;
            cop_q <= '0;
            ca_q  <= '0;
            cb_q  <= '0;
            cd_q  <= '0;
        end else if (capture) begin
            cv_q  <= 1'b1;
            cop_q <= op_q;
            ca_q  <= a_q;
            cb_q  <= b_q;
            cd_q  <= md_result;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    // State, operand, result and watchdog registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            wdog_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            wdog_q  <= wdog_d;
            terr_q  <= terr_d;
        end
    end

    // Next-state logic: accept, issue, wait/drain and writeback sequencing.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        data_d  = data_q;
        terr_d  = terr_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = req_op;
                    a_d  = req_rs1;
                    b_d  = req_rs2;
                    rd_d = req_rd;
                    if (req_rd == 5'd0) begin
                        state_d = S_IDLE;           // x0 target: consumed silently
                    end else if (cache_hit) begin
                        data_d  = cache_data;
                        state_d = S_WB;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE, S_WAIT: begin
                if (flush) begin
                    state_d = md_done ? S_IDLE : S_DRAIN;
                end else if (md_done) begin
                    data_d  = md_result;
                    state_d = S_WB;
                end else if (state_q == S_ISSUE) begin
                    state_d = S_WAIT;
                end else if (wdog_expire) begin
                    data_d  = '0;
                    terr_d  = 1'b1;
                    state_d = S_WB;
                end
            end
            S_DRAIN: begin
                if (md_done) begin
                    state_d = S_IDLE;
                end else if (wdog_expire) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WB: begin
                if (flush || wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Watchdog restarts from zero whenever WAIT or DRAIN is newly entered.
    always_comb begin
        wdog_d = 8'd0;
        if (((state_d == S_WAIT) || (state_d == S_DRAIN)) && (state_d == state_q)) begin
            wdog_d = wdog_inc;
        end
    end

    // reset gates req_ready so every output reads 0 while reset is held.
    assign req_ready   = (state_q == S_IDLE) & ~flush & ~reset;
    assign md_start    = (state_q == S_ISSUE);
    assign wb_valid    = (state_q == S_WB);
    assign busy        = (state_q != S_IDLE);
    assign md_op       = op_q;
    assign md_A        = a_q;
    assign md_B        = b_q;
    assign wb_rd       = rd_q;
    assign wb_data     = data_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Testbench for muldiv_issue_ctrl: directed operations, expected writebacks
// queued by the stimulus and checked by an independent monitor.
module tb_muldiv_issue_ctrl;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] md_A, md_B;
    logic        md_done;
    logic [31:0] md_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
    logic        timeout_err;

    muldiv_issue_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .flush(flush),
        .md_start(md_start), .md_op(md_op), .md_A(md_A), .md_B(md_B),
        .md_done(md_done), .md_result(md_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    int start_cnt  = 0;
    int last_start = -1;
    int wb_rise    = -1;
    logic prev_wb  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] data, input int c);
        wb_exp_t e;
        e.rd = rd; e.data = data; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Monitor: counts start pulses and checks every completed writeback.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_wb = 1'b0;
            end else begin
                if (md_start) begin
                    start_cnt++;
                    last_start = cyc;
                end
                if (wb_valid && !prev_wb) wb_rise = cyc;
                prev_wb = wb_valid;
                if (wb_valid && wb_ready && !flush) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL wb_unexpected: got rd=%0d data=%0h expected no writeback (cycle %0d)",
                                 wb_rd, wb_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                        chk("wb_data", wb_data, e.data);
                        chk("wb_valid_cycle", wb_rise, e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) tick();
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rd, output int t);
        req_valid = 1'b1;
        req_op    = op;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_rd    = rd;
        @(negedge clk);
        chk("req_ready_on_issue", 32'(req_ready), 32'd1);
        t = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic pulse_done(input int n, input logic [31:0] r);
        at_cycle(n);
        md_done   = 1'b1;
        md_result = r;
        tick();
        md_done   = 1'b0;
    endtask

    // Global bound so the run can never hang.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation bound expired");
    end

    initial begin
        int t, t1, t2, s;
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
        flush = 1'b0; md_done = 1'b0; md_result = '0; wb_ready = 1'b1;

        // Reset state.
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_md_start", 32'(md_start), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);

        // MUL 7x6 -> 42, done at T+3, writeback stalled three cycles.
        tick();
        issue(3'd0, 32'd7, 32'd6, 5'd5, t);
        push_exp(5'd5, 32'd42, t + 4);
        wb_ready = 1'b0;
        @(negedge clk);
        chk("mul_md_start", 32'(md_start), 32'd1);
        chk("mul_md_A", md_A, 32'd7);
        chk("mul_md_B", md_B, 32'd6);
        chk("mul_md_op", 32'(md_op), 32'd0);
        pulse_done(t + 3, 32'd42);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mul_hold_valid", 32'(wb_valid), 32'd1);
            chk("mul_hold_data", wb_data, 32'd42);
            chk("mul_hold_rd", 32'(wb_rd), 32'd5);
            tick();
        end
        wb_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("mul_req_ready_after_wb", 32'(req_ready), 32'd1);
        chk("mul_start_count", start_cnt, 1);
        chk("mul_start_cycle", last_start, t + 1);

        // DIV by zero with a fast same-cycle done.
        tick();
        issue(3'd4, 32'd10, 32'd0, 5'd3, t);
        push_exp(5'd3, 32'hFFFF_FFFF, t + 2);
        pulse_done(t + 1, 32'hFFFF_FFFF);
        tick();

        // DIVU 100/7 flushed in WAIT -> DRAIN, done at T+20, no writeback.
        issue(3'd5, 32'd100, 32'd7, 5'd9, t);
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_req_ready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("drain_busy", 32'(busy), 32'd1);
        at_cycle(t + 20);
        md_done = 1'b1;
        md_result = 32'd14;
        @(negedge clk);
        chk("drain_req_ready", 32'(req_ready), 32'd0);
        tick();
        md_done = 1'b0;
        @(negedge clk);
        chk("drain_exit_req_ready", 32'(req_ready), 32'd1);
        chk("drain_no_wb", 32'(wb_valid), 32'd0);

        // rd=0 consumed silently, then a back-to-back MULHU.
        tick();
        s = start_cnt;
        issue(3'd0, 32'd3, 32'd4, 5'd0, t1);
        issue(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd7, t2);
        push_exp(5'd7, 32'd1, t2 + 3);
        pulse_done(t2 + 2, 32'd1);
        tick();
        tick();
        chk("x0_start_count", start_cnt, s + 1);
        chk("x0_start_cycle", last_start, t2 + 1);

        // Watchdog: md_done never arrives.
        issue(3'd0, 32'd1, 32'd1, 5'd4, t);
        push_exp(5'd4, 32'd0, t + TIMEOUT + 1);
        wb_ready = 1'b0;
        at_cycle(t + TIMEOUT);
        @(negedge clk);
        chk("wdog_not_yet", 32'(wb_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("wdog_wb_valid", 32'(wb_valid), 32'd1);
        chk("wdog_wb_data", wb_data, 32'd0);
        chk("wdog_timeout_err", 32'(timeout_err), 32'd1);
        tick();
        wb_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("wdog_sticky", 32'(timeout_err), 32'd1);
        chk("wdog_req_ready", 32'(req_ready), 32'd1);

        // Reset while in WAIT clears every output immediately.
        tick();
        issue(3'd1, 32'd5, 32'd5, 5'd6, t);
        at_cycle(t + 3);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_timeout_err", 32'(timeout_err), 32'd0);
        chk("arst_md_A", md_A, 32'd0);
        chk("arst_md_B", md_B, 32'd0);
        chk("arst_md_op", 32'(md_op), 32'd0);
        chk("arst_wb_rd", 32'(wb_rd), 32'd0);
        chk("arst_wb_data", wb_data, 32'd0);
        chk("arst_md_start", 32'(md_start), 32'd0);
        chk("arst_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // REM 17,5 twice, then REM 17,6.
        s = start_cnt;
        issue(3'd6, 32'd17, 32'd5, 5'd8, t);
        push_exp(5'd8, 32'd2, t + 3);
        pulse_done(t + 2, 32'd2);
        tick();
        issue(3'd6, 32'd17, 32'd5, 5'd10, t);
`ifdef MULDIV_RESULT_CACHE_EN
        push_exp(5'd10, 32'd2, t + 1);
`else
        push_exp(5'd10, 32'd2, t + 2);
`endif
        pulse_done(t + 1, 32'd2);
        tick();
        tick();
`ifdef MULDIV_RESULT_CACHE_EN
        chk("rem_repeat_start_count", start_cnt, s + 1);
`else
        chk("rem_repeat_start_count", start_cnt, s + 2);
`endif
        issue(3'd6, 32'd17, 32'd6, 5'd11, t);
        push_exp(5'd11, 32'd5, t + 3);
        pulse_done(t + 2, 32'd5);
        tick();
        tick();
        chk("rem_new_start_cycle", last_start, t + 1);

        // Flush in WB wins over a same-cycle wb_ready: result dropped.
        issue(3'd0, 32'd2, 32'd3, 5'd12, t);
        wb_ready = 1'b0;
        pulse_done(t + 1, 32'd6);
        flush = 1'b1;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("wbflush_valid", 32'(wb_valid), 32'd1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("wbflush_dropped", 32'(wb_valid), 32'd0);
        chk("wbflush_req_ready", 32'(req_ready), 32'd1);

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_issue_ctrl.md
# muldiv_issue_ctrl

Issue and writeback sequencer between the core's execute stage and the MULDIV unit. Accepts one M-extension operation at a time over a valid/ready handshake and registers its operands. Starts the MULDIV unit, waits for its done, and returns the result with its destination register over a valid/ready writeback port. Also handles pipeline flush while an operation is in flight, the x0 destination, a completion watchdog and an optional last-result cache.

## Interface
- TIMEOUT, 64: maximum cycles allowed in WAIT/DRAIN before the watchdog fires. Range 2..255.
- clk  in  1  system clock; all flops on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  operation request.
- req_ready  out  1  request accepted when high together with req_valid.
- req_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_rs1, req_rs2  in  32  operands.
- req_rd  in  5  destination register.
- flush  in  1  kill any in-flight operation.
- md_start  out  1  one-cycle start pulse to the MULDIV unit.
- md_op  out  3  registered op (bit 2 = muldiv_sel).
- md_A, md_B  out  32  registered operands; stable from ISSUE until done.
- md_done  in  1  MULDIV completion; may be high in the same cycle as md_start (fast result).
- md_result  in  32  valid while md_done is high.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback accepted.
- wb_rd  out  5  destination register.
- wb_data  out  32  result.
- busy  out  1  high when the state is not IDLE.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- States: IDLE, ISSUE, WAIT, WB, DRAIN.
- Reset value of every output is 0. State resets to IDLE and the cache is invalidated.
- Outputs per state:
  - req_ready = (state==IDLE) & ~flush.
  - md_start = (state==ISSUE).
  - wb_valid = (state==WB).
- IDLE: on accept, register op/rs1/rs2/rd.
  - rd==0 → stay in IDLE. No md_start and no writeback; the op is consumed.
  - Cache hit → WB with cached data.
  - Otherwise → ISSUE.
- ISSUE:
  - md_done → capture md_result, go to WB.
  - Else → WAIT.
  - flush without md_done → DRAIN.
  - flush with md_done → IDLE; result discarded.
- WAIT:
  - md_done → capture, go to WB.
  - flush → DRAIN; flush with md_done → IDLE.
  - Watchdog expires → WB with wb_data=0 and timeout_err set.
- DRAIN: wait for md_done or the watchdog, then IDLE. No writeback. flush is ignored.
- WB: hold wb_rd/wb_data until wb_ready, then IDLE.
  - flush drops the result → IDLE. flush wins over a same-cycle wb_ready.
- Watchdog: 8-bit counter, cleared on entry to WAIT/DRAIN, increments each cycle in WAIT/DRAIN. Expiry when count==TIMEOUT-1.
- Only one operation is outstanding. A new accept is possible only from IDLE.

## Timing
- Accept at cycle T → md_start at T+1.
- Fast result (md_done at T+1) → wb_valid at T+2.
- md_done at cycle D > T+1 → wb_valid at D+1.
- Cache hit → wb_valid at T+1.
- After a WB handshake at cycle W, req_ready is high at W+1.
- md_A/md_B/md_op change only on accept.

## Configuration
- MULDIV_RESULT_CACHE_EN defined: a single-entry cache {valid, op, rs1, rs2, data}.
  - Updated whenever a result is captured from md_done in ISSUE/WAIT.
  - Not updated on drained, discarded or timed-out operations.
  - A hit requires valid and an exact match on op, rs1 and rs2. Flush does not invalidate the cache.
- Undefined: there is no cache logic and every rd≠0 request goes through ISSUE.

## Test plan
- MUL 7×6, rd=5, md_done at T+3 → md_start at T+1 only, wb_valid at T+4 with wb_rd=5, wb_data=42. Hold wb_ready low 3 cycles → data stable, then IDLE.
- DIV with rs2=0, md_done in the same cycle as md_start, md_result=FFFFFFFF → wb_valid at T+2 with data FFFFFFFF.
- DIVU 100/7 with flush at T+2 in WAIT → DRAIN. md_done at T+20 → no wb_valid; req_ready high at T+21.
- MUL with rd=0 → req_ready stays high, no md_start, no wb_valid. A back-to-back request is accepted next cycle.
- md_done never asserted, TIMEOUT=64 → wb_valid with wb_data=0 at T+65 and timeout_err=1 until reset. Reset asserted in WAIT → all outputs 0 at once.
- MULDIV_RESULT_CACHE_EN: REM 17,5 completes with 2, then REM 17,5 again → no md_start, wb_valid at T+1, data 2. REM 17,6 → normal issue.
